// File: rtl/maxpool_1d_fp_if.sv
// Stream bundle between the BN+ReLU stage, the temporal max-pool and the
// next conv stage.
interface maxpool_1d_fp_if #(
  parameter int NO_CH = 10,
  parameter int BW    = 12
);
  logic                       vld_in;
  logic [NO_CH-1:0][BW-1:0]   data_in;
  logic                       vld_out;
  logic [NO_CH-1:0][BW-1:0]   data_out;
  logic                       last_out;

  modport master (
    output vld_in, data_in,
    input  vld_out, data_out, last_out
  );

  modport slave (
    input  vld_in, data_in,
    output vld_out, data_out, last_out
  );
endinterface

// File: rtl/maxpool_1d_fp.sv
// Frame-aware temporal max-pool: per-channel signed max over POOL valid
// vectors, partial window closes each SEQ_LEN frame and is flagged last.
module maxpool_1d_fp #(
  parameter int NO_CH   = 10,
  parameter int BW      = 12,
  parameter int POOL    = 2,
  parameter int SEQ_LEN = 1024
) (
  input  logic          clk,
  input  logic          rst,
  maxpool_1d_fp_if.slave io
);

  localparam int WCW = $clog2(POOL);
  localparam int SCW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  logic [WCW-1:0]        win_cnt;
  logic [SCW-1:0]        seq_cnt;
  logic signed [BW-1:0]  acc [NO_CH];
  logic signed [BW-1:0]  nxt [NO_CH];
  logic                  last_seq;
  logic                  close;

  assign last_seq = (seq_cnt == SCW'(SEQ_LEN - 1));
  assign close    = (win_cnt == WCW'(POOL - 1)) || last_seq;

  // First sample of a window replaces the stale accumulator.
  always_comb begin
    for (int i = 0; i < NO_CH; i++) begin
      nxt[i] = acc[i];
      if (win_cnt == '0 || $signed(io.data_in[i]) > acc[i])
        nxt[i] = io.data_in[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      win_cnt     <= '0;
      seq_cnt     <= '0;
      io.vld_out  <= 1'b0;
      io.last_out <= 1'b0;
      io.data_out <= '0;
      for (int i = 0; i < NO_CH; i++)
        acc[i] <= '0;
    end else begin
      io.vld_out  <= io.vld_in && close;
      io.last_out <= io.vld_in && last_seq;
      if (io.vld_in) begin
        for (int i = 0; i < NO_CH; i++) begin
          acc[i] <= nxt[i];
          if (close)
            io.data_out[i] <= nxt[i];
        end
        win_cnt <= close ? '0 : win_cnt + WCW'(1);
        seq_cnt <= last_seq ? '0 : seq_cnt + SCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_maxpool_1d_fp.sv
// Random and directed stimulus shared by three max-pool configurations,
// each checked cycle-by-cycle against a window-list reference model.
module tb_maxpool_1d_fp;

  localparam int NO_CH = 10;
  localparam int BW    = 12;
  localparam int P [3] = '{2, 4, 2};
  localparam int S [3] = '{1024, 6, 5};

  typedef logic [NO_CH-1:0][BW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  logic vld;
  vec_t din;

  always #5 clk = ~clk;

  maxpool_1d_fp_if #(.NO_CH(NO_CH), .BW(BW)) ia ();
  maxpool_1d_fp_if #(.NO_CH(NO_CH), .BW(BW)) ib ();
  maxpool_1d_fp_if #(.NO_CH(NO_CH), .BW(BW)) ic ();

  assign ia.vld_in  = vld;
  assign ia.data_in = din;
  assign ib.vld_in  = vld;
  assign ib.data_in = din;
  assign ic.vld_in  = vld;
  assign ic.data_in = din;

  maxpool_1d_fp #(.NO_CH(NO_CH), .BW(BW), .POOL(2), .SEQ_LEN(1024)) dut_a (
    .clk(clk), .rst(rst), .io(ia)
  );
  maxpool_1d_fp #(.NO_CH(NO_CH), .BW(BW), .POOL(4), .SEQ_LEN(6)) dut_b (
    .clk(clk), .rst(rst), .io(ib)
  );
  maxpool_1d_fp #(.NO_CH(NO_CH), .BW(BW), .POOL(2), .SEQ_LEN(5)) dut_c (
    .clk(clk), .rst(rst), .io(ic)
  );

  vec_t win_q [3][$];
  int   pos [3];
  logic e_vld [3];
  logic e_last [3];
  vec_t e_data [3];
  bit   in_rst;
  int   n_vld_a;
  int   n_last_a;
  int   checks;
  int   failures;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic vec_t win_max(int m);
    vec_t r;
    for (int c = 0; c < NO_CH; c++) begin
      int best;
      best = -(1 << 30);
      foreach (win_q[m][k]) begin
        int v;
        v = int'($signed(win_q[m][k][c]));
        if (v > best) best = v;
      end
      r[c] = best[BW-1:0];
    end
    return r;
  endfunction

  task automatic model(int m);
    e_vld[m]  = 1'b0;
    e_last[m] = 1'b0;
    if (!rst) begin
      win_q[m].delete();
      pos[m]    = 0;
      e_data[m] = '0;
    end else if (vld) begin
      win_q[m].push_back(din);
      pos[m]++;
      if (win_q[m].size() == P[m] || pos[m] == S[m]) begin
        e_vld[m]  = 1'b1;
        e_last[m] = (pos[m] == S[m]);
        e_data[m] = win_max(m);
        win_q[m].delete();
        if (pos[m] == S[m]) pos[m] = 0;
      end
    end
  endtask

  task automatic check_out(string n, int m, logic vo, vec_t d, logic lo);
    check({n, "_vld"}, 128'(vo), 128'(e_vld[m]));
    if (e_vld[m]) begin
      check({n, "_data"}, 128'(d), 128'(e_data[m]));
      check({n, "_last"}, 128'(lo), 128'(e_last[m]));
    end
    if (in_rst) begin
      check({n, "_rst_data"}, 128'(d), 128'(0));
      check({n, "_rst_last"}, 128'(lo), 128'(0));
    end
  endtask

  task automatic step(logic r, logic v, vec_t d);
    rst = r;
    vld = v;
    din = d;
    @(posedge clk);
    in_rst = !r;
    for (int m = 0; m < 3; m++) model(m);
    @(negedge clk);
    check_out("a", 0, ia.vld_out, ia.data_out, ia.last_out);
    check_out("b", 1, ib.vld_out, ib.data_out, ib.last_out);
    check_out("c", 2, ic.vld_out, ic.data_out, ic.last_out);
    if (ia.vld_out) n_vld_a++;
    if (ia.vld_out && ia.last_out) n_last_a++;
  endtask

  function automatic vec_t rnd_vec();
    vec_t r;
    for (int c = 0; c < NO_CH; c++) begin
      case ($urandom_range(0, 5))
        0:       r[c] = 12'h800;
        1:       r[c] = 12'h7FF;
        2:       r[c] = 12'hFFF;
        3:       r[c] = 12'h000;
        default: r[c] = BW'($urandom);
      endcase
    end
    return r;
  endfunction

  function automatic vec_t ch0_vec(int v);
    vec_t r;
    r    = rnd_vec();
    r[0] = BW'(v);
    return r;
  endfunction

  int   t1 [4] = '{3, 7, 5, 2};
  int   t5 [4] = '{1, 1, 1, 6};
  int   pa [3] = '{-2048, 2047, -5};
  int   pb [3] = '{-1, -2048, -5};

  initial begin
    checks   = 0;
    failures = 0;
    n_vld_a  = 0;
    n_last_a = 0;
    in_rst   = 1'b0;
    rst      = 1'b0;
    vld      = 1'b0;
    din      = '0;

    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // basic window, back to back
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, ch0_vec(t1[i]));
    step(1'b1, 1'b0, '0);

    // signed extremes, distinct per channel
    for (int p = 0; p < 3; p++) begin
      vec_t va, vb;
      for (int c = 0; c < NO_CH; c++) begin
        va[c] = BW'(pa[(c + p) % 3] + ((c + p) % 3 == 2 ? -c : 0));
        vb[c] = BW'(pb[(c + p) % 3] + ((c + p) % 3 == 2 ? -c : 0));
      end
      step(1'b1, 1'b1, va);
      step(1'b1, 1'b1, vb);
    end

    // idle gaps of three cycles between inputs
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, ch0_vec(t1[i % 4]));
      for (int g = 0; g < 3; g++) step(1'b1, 1'b0, rnd_vec());
    end

    for (int i = 0; i < 200; i++)
      step(1'b1, ($urandom_range(0, 3) == 0), rnd_vec());

    // reset in the middle of a window
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, ch0_vec(100));
    step(1'b1, 1'b1, ch0_vec(200));
    step(1'b0, 1'b1, ch0_vec(300));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, ch0_vec(t5[i]));
    step(1'b1, 1'b0, '0);

    // continuous streaming, three full frames of the 1024 configuration
    step(1'b0, 1'b0, '0);
    n_vld_a  = 0;
    n_last_a = 0;
    for (int i = 0; i < 3 * 1024; i++) step(1'b1, 1'b1, rnd_vec());
    check("a_frame_results", 128'(n_vld_a), 128'(1536));
    check("a_frame_lasts", 128'(n_last_a), 128'(3));

    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), rnd_vec());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
